imm_gen_stage: RTL

Registered, parametrised immediate-generation stage between fetch and decode. Extracts and sign/zero-extends the immediate for every RV32I/RV64I base format plus shift-amount and CSR-immediate forms, flags undefined encodings instead of emitting X, and precomputes PC-relative targets. A valid/ready interface with a 2-entry skid buffer lets the stage absorb back-pressure without dropping instructions.

---
 rtl/imm_pkg.sv | 44 ++++
 rtl/imm_gen_stage_if.sv | 28 ++
 rtl/imm_decode.sv | 123 ++++++++++++
 rtl/imm_gen_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared opcode, funct3 and immediate-format definitions for the immediate generation stage.
package imm_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_SLL      = 3'b001;
    localparam logic [2:0] F3_SRX      = 3'b101;
    localparam logic [2:0] F3_PRIV     = 3'b000;
    localparam logic [2:0] F3_CSRRW    = 3'b001;
    localparam logic [2:0] F3_CSRRS    = 3'b010;
    localparam logic [2:0] F3_CSRRC    = 3'b011;
    localparam logic [2:0] F3_SYS_RSVD = 3'b100;
    localparam logic [2:0] F3_CSRRWI   = 3'b101;
    localparam logic [2:0] F3_CSRRSI   = 3'b110;
    localparam logic [2:0] F3_CSRRCI   = 3'b111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_Z    = 3'd7
    } fmt_e;

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRX);
    endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bus between fetch, the immediate stage and decode.
interface imm_gen_stage_if #(parameter int XLEN = 32);
    import imm_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic            out_illegal;
    logic [XLEN-1:0] out_target;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal, out_target
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal, out_target
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate extraction, format/illegal classification and PC-relative target.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal,
    output logic [XLEN-1:0] target
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            use_target;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr, imm_zimm, shamt5, shamt6;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Signed size casts sign-extend from instr[31] whatever XLEN is.
    assign imm_i    = XLEN'($signed(instr[31:20]));
    assign imm_s    = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b    = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_csr  = XLEN'(instr[31:20]);
    assign imm_zimm = XLEN'(instr[19:15]);
    assign shamt5   = XLEN'(instr[24:20]);
    assign shamt6   = XLEN'(instr[25:20]);

    always_comb begin
        imm        = '0;
        fmt        = FMT_NONE;
        illegal    = 1'b0;
        use_target = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OP_LOAD, OP_JALR: begin
                    fmt = FMT_I;
                    imm = imm_i;
                end
                OP_IMM: begin
                    if (is_shift(funct3)) begin
                        fmt     = FMT_SH;
                        imm     = RV64 ? shamt6 : shamt5;
                        illegal = !RV64 && instr[25];
                    end else begin
                        fmt = FMT_I;
                        imm = imm_i;
                    end
                end
                OP_IMM_32: begin
                    if (!RV64) begin
                        illegal = 1'b1;
                    end else if (is_shift(funct3)) begin
                        fmt     = FMT_SH;
                        imm     = shamt5;
                        illegal = instr[25];
                    end else begin
                        fmt = FMT_I;
                        imm = imm_i;
                    end
                end
                OP_STORE: begin
                    fmt = FMT_S;
                    imm = imm_s;
                end
                OP_BRANCH: begin
                    fmt        = FMT_B;
                    imm        = imm_b;
                    use_target = 1'b1;
                end
                OP_LUI: begin
                    fmt = FMT_U;
                    imm = imm_u;
                end
                OP_AUIPC: begin
                    fmt        = FMT_U;
                    imm        = imm_u;
                    use_target = 1'b1;
                end
                OP_JAL: begin
                    fmt        = FMT_J;
                    imm        = imm_j;
                    use_target = 1'b1;
                end
                OP_SYSTEM: begin
                    case (funct3)
                        F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: begin
                            fmt = FMT_Z;
                            imm = imm_zimm;
                        end
                        F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
                            fmt = FMT_I;
                            imm = imm_csr;
                        end
                        F3_PRIV:     fmt     = FMT_NONE;
                        F3_SYS_RSVD: illegal = 1'b1;
                        default:     illegal = 1'b1;
                    endcase
                end
                OP_OP, OP_MISC_MEM: fmt = FMT_NONE;
                OP_OP_32:           illegal = !RV64;
                default:            illegal = 1'b1;
            endcase
        end
        if (illegal) begin
            imm        = '0;
            fmt        = FMT_NONE;
            use_target = 1'b0;
        end
    end

    assign target = use_target ? pc + imm : '0;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate stage: decode on the input side, 2-entry skid buffer on the output side.
//   state    | meaning
//   ST_EMPTY | no entry held, out_valid low
//   ST_MAIN  | main register holds the output entry, skid empty
//   ST_FULL  | main and skid both hold entries, in_ready low
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    imm_gen_stage_if.slave  bus
);

    typedef enum logic [1:0] {ST_EMPTY, ST_MAIN, ST_FULL} state_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
        logic [XLEN-1:0] target;
    } entry_t;

    state_e state, state_nxt;
    entry_t main_q, skid_q, dec;
    logic   in_ready_q, out_valid_q;
    logic   accept, load_main_in, load_main_skid, load_skid;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.in_instr),
        .pc      (bus.in_pc),
        .imm     (dec.imm),
        .fmt     (dec.fmt),
        .illegal (dec.illegal),
        .target  (dec.target)
    );
    assign dec.instr = bus.in_instr;
    assign dec.pc    = bus.in_pc;

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_nxt    = ST_MAIN;
                end
            end
            ST_MAIN: begin
                if (bus.out_ready) begin
                    if (accept) load_main_in = 1'b1;
                    else        state_nxt    = ST_EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ST_MAIN;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // A flush discards held entries and the same-cycle input alike.
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt != ST_FULL);
            out_valid_q <= (state_nxt != ST_EMPTY);
            if (load_main_in)   main_q <= dec;
            if (load_main_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= dec;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = main_q.instr;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_illegal = main_q.illegal;
    assign bus.out_target  = main_q.target;

endmodule
